// File: rtl/blake2_pmod_host.sv
// Host-side initiator for the Pmod hash link: streams a message to the hasher, then collects the digest.
// Define BLAKE2_HOST_TIMEOUT_EN to build the digest watchdog; without it WAIT_HASH waits indefinitely.
module blake2_pmod_host #(
  parameter int BLOCK_BYTES = 64,
  parameter int HASH_BYTES  = 32,
  parameter int TIMEOUT_W   = 16
) (
  input  logic       clk,
  input  logic       rst_async,
  input  logic       msg_valid_i,
  input  logic [7:0] msg_data_i,
  input  logic       msg_last_i,
  output logic       msg_ready_o,
  output logic [7:0] data_o,
  output logic [2:0] data_ctrl_o,
  input  logic [7:0] hash_i,
  input  logic [1:0] hash_ctrl_i,
  output logic       res_valid_o,
  output logic [7:0] res_data_o,
  output logic       res_last_o,
  output logic       busy_o,
  output logic       error_o
);

  localparam int BW = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
  localparam int DW = (HASH_BYTES > 1) ? $clog2(HASH_BYTES) : 1;

  if (BLOCK_BYTES < 2 || (BLOCK_BYTES & (BLOCK_BYTES - 1)) != 0) begin : g_bad_block
    $error("BLOCK_BYTES must be a power of two and at least 2");
  end
  if (TIMEOUT_W < 1) begin : g_bad_timeout
    $error("TIMEOUT_W must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RDY,
    SEND,
    WAIT_HASH,
    RECV
  } state_t;

  state_t                 state;
  (* IOB = "TRUE" *) logic [7:0] hash_s1;
  (* IOB = "TRUE" *) logic [1:0] hctrl_s1;
  logic [7:0]             hash_s2;
  logic [1:0]             hctrl_s2;
  logic                   hv;
  logic                   hb;
  logic [BW-1:0]          blk_cnt;
  logic [DW-1:0]          dig_cnt;
  logic                   rdy_seen;
`ifdef BLAKE2_HOST_TIMEOUT_EN
  logic [TIMEOUT_W-1:0]   wdog;
`endif

  // The hasher runs on its own clock, so its bus is double-flopped before any decision uses it.
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      hash_s1  <= 8'h00;
      hctrl_s1 <= 2'b00;
      hash_s2  <= 8'h00;
      hctrl_s2 <= 2'b00;
    end else begin
      hash_s1  <= hash_i;
      hctrl_s1 <= hash_ctrl_i;
      hash_s2  <= hash_s1;
      hctrl_s2 <= hctrl_s1;
    end
  end

  assign hv = hctrl_s2[0];
  assign hb = hctrl_s2[1];

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      state       <= IDLE;
      msg_ready_o <= 1'b0;
      data_o      <= 8'h00;
      data_ctrl_o <= 3'b000;
      res_valid_o <= 1'b0;
      res_data_o  <= 8'h00;
      res_last_o  <= 1'b0;
      busy_o      <= 1'b0;
      error_o     <= 1'b0;
      blk_cnt     <= '0;
      dig_cnt     <= '0;
      rdy_seen    <= 1'b0;
`ifdef BLAKE2_HOST_TIMEOUT_EN
      wdog        <= '0;
`endif
    end else begin
      data_ctrl_o <= 3'b000;
      res_valid_o <= 1'b0;
      res_last_o  <= 1'b0;

      case (state)
        IDLE: begin
          if (hv) error_o <= 1'b1;
`ifdef BLAKE2_HOST_TIMEOUT_EN
          wdog <= '0;
`endif
          if (msg_valid_i) begin
            state    <= WAIT_RDY;
            busy_o   <= 1'b1;
            rdy_seen <= 1'b0;
          end
        end

        // Two consecutive not-busy samples are needed before committing a whole block.
        WAIT_RDY: begin
          if (hv) error_o <= 1'b1;
          if (hb) begin
            rdy_seen <= 1'b0;
          end else if (rdy_seen) begin
            state       <= SEND;
            msg_ready_o <= 1'b1;
            rdy_seen    <= 1'b0;
          end else begin
            rdy_seen <= 1'b1;
          end
        end

        SEND: begin
          if (hv) error_o <= 1'b1;
          if (msg_valid_i && msg_ready_o) begin
            data_o      <= msg_data_i;
            data_ctrl_o <= {msg_last_i, blk_cnt == '0, 1'b1};
            blk_cnt     <= blk_cnt + BW'(1);
            // Last takes priority over a block wrap; the hasher pads the final block itself.
            if (msg_last_i) begin
              blk_cnt     <= '0;
              state       <= WAIT_HASH;
              msg_ready_o <= 1'b0;
`ifdef BLAKE2_HOST_TIMEOUT_EN
              wdog        <= '0;
`endif
            end else if (blk_cnt == BW'(BLOCK_BYTES - 1)) begin
              state       <= WAIT_RDY;
              msg_ready_o <= 1'b0;
            end
          end
        end

        WAIT_HASH, RECV: begin
          if (hv) begin
            res_valid_o <= 1'b1;
            res_data_o  <= hash_s2;
            if (dig_cnt == DW'(HASH_BYTES - 1)) begin
              res_last_o <= 1'b1;
              state      <= IDLE;
              busy_o     <= 1'b0;
              dig_cnt    <= '0;
            end else begin
              dig_cnt <= dig_cnt + DW'(1);
              state   <= RECV;
            end
          end else if (state == RECV) begin
            error_o <= 1'b1;
            state   <= IDLE;
            busy_o  <= 1'b0;
            dig_cnt <= '0;
          end
`ifdef BLAKE2_HOST_TIMEOUT_EN
          if (hv) begin
            wdog <= '0;
          end else if (wdog == '1) begin
            error_o <= 1'b1;
            state   <= IDLE;
            busy_o  <= 1'b0;
            dig_cnt <= '0;
          end else begin
            wdog <= wdog + TIMEOUT_W'(1);
          end
`endif
        end

        default: begin
          state       <= IDLE;
          msg_ready_o <= 1'b0;
          busy_o      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_blake2_pmod_host.sv
// Scoreboard bench for blake2_pmod_host: a behavioural hasher sits on the Pmod pins, a monitor checks both output ports.
`timescale 1ns/1ps
module tb_blake2_pmod_host;

`ifdef BLAKE2_HOST_TIMEOUT_EN
  localparam int TW = 8;
`else
  localparam int TW = 16;
`endif
  localparam int BLOCK     = 64;
  localparam int HASH      = 32;
  localparam int ANS_DELAY = 100;
  localparam int BUSY_GAP  = 20;
  localparam int LIMIT     = 2000;

  logic       clk = 1'b0;
  logic       rst_async = 1'b1;
  logic       msg_valid_i = 1'b0;
  logic [7:0] msg_data_i = 8'h00;
  logic       msg_last_i = 1'b0;
  logic       msg_ready_o;
  logic [7:0] data_o;
  logic [2:0] data_ctrl_o;
  logic [7:0] hash_i = 8'h00;
  logic [1:0] hash_ctrl_i = 2'b00;
  logic       res_valid_o;
  logic [7:0] res_data_o;
  logic       res_last_o;
  logic       busy_o;
  logic       error_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [10:0] exp_beat_q[$];
  logic [8:0]  exp_res_q[$];

  int         ans_count = HASH;
  logic [7:0] ans_base = 8'h00;
  bit         never_answer = 1'b0;

  int m_cnt, m_gap, m_wait, m_left, m_idx, end_cyc;
  bit gap_pending;

  blake2_pmod_host #(
    .BLOCK_BYTES(BLOCK),
    .HASH_BYTES (HASH),
    .TIMEOUT_W  (TW)
  ) dut (
    .clk        (clk),
    .rst_async  (rst_async),
    .msg_valid_i(msg_valid_i),
    .msg_data_i (msg_data_i),
    .msg_last_i (msg_last_i),
    .msg_ready_o(msg_ready_o),
    .data_o     (data_o),
    .data_ctrl_o(data_ctrl_o),
    .hash_i     (hash_i),
    .hash_ctrl_i(hash_ctrl_i),
    .res_valid_o(res_valid_o),
    .res_data_o (res_data_o),
    .res_last_o (res_last_o),
    .busy_o     (busy_o),
    .error_o    (error_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one message; abort_after stops before that byte index, drop_at idles valid for 3 cycles.
  task automatic applyStimulus(input int n, input logic [7:0] seed, input int abort_after, input int drop_at);
    int guard;
    for (int i = 0; i < n; i++) begin
      if (i == abort_after) begin
        msg_valid_i = 1'b0;
        return;
      end
      if (i == drop_at) begin
        msg_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
      end
      msg_valid_i = 1'b1;
      msg_data_i  = seed + 8'(i * 7);
      msg_last_i  = (i == n - 1);
      @(negedge clk);
      guard = 0;
      while (!msg_ready_o && guard < LIMIT) begin
        @(negedge clk);
        guard++;
      end
      if (!msg_ready_o) begin
        checkOutput("accept_timeout", i, n);
        msg_valid_i = 1'b0;
        return;
      end
      exp_beat_q.push_back({(i == n - 1), (i % BLOCK == 0), 1'b1, msg_data_i});
      @(posedge clk);
      #1;
    end
    msg_valid_i = 1'b0;
    msg_last_i  = 1'b0;
  endtask

  task automatic expectDigest(input logic [7:0] base, input int count);
    for (int k = 0; k < count; k++)
      exp_res_q.push_back({(count == HASH && k == HASH - 1), base + 8'(k)});
  endtask

  task automatic waitDigest(input string name);
    int guard = 0;
    int ready_seen = 0;
    while (exp_res_q.size() != 0 && guard < LIMIT) begin
      @(negedge clk);
      #1;
      if (msg_ready_o) ready_seen++;
      guard++;
    end
    checkOutput({name, "_digest_done"}, exp_res_q.size(), 0);
    checkOutput({name, "_no_ready"}, ready_seen, 0);
    exp_res_q.delete();
    repeat (4) @(negedge clk);
  endtask

  // Monitor: every beat on either output port is popped against the scoreboard.
  always @(negedge clk) begin
    if (!rst_async) begin
      if (data_ctrl_o[0]) begin
        if (exp_beat_q.size() == 0) checkOutput("spurious_beat", {data_ctrl_o, data_o}, 0);
        else checkOutput("data_beat", {data_ctrl_o, data_o}, exp_beat_q.pop_front());
      end else if (data_ctrl_o != 3'b000) begin
        checkOutput("ctrl_idle", data_ctrl_o, 0);
      end
      if (res_valid_o) begin
        if (exp_res_q.size() == 0) checkOutput("spurious_res", {res_last_o, res_data_o}, 0);
        else checkOutput("res_byte", {res_last_o, res_data_o}, exp_res_q.pop_front());
      end else if (res_last_o) begin
        checkOutput("res_last_idle", res_last_o, 0);
      end
    end
  end

  // Hasher model: busy from the first beat of a block, held BUSY_GAP cycles after a full block,
  // and answers ans_count digest bytes ANS_DELAY cycles after the last beat.
  always @(negedge clk or posedge rst_async) begin
    if (rst_async) begin
      hash_i      = 8'h00;
      hash_ctrl_i = 2'b00;
      m_cnt = 0; m_gap = 0; m_wait = 0; m_left = 0; m_idx = 0;
      gap_pending = 1'b0;
    end else begin
      if (data_ctrl_o[0]) begin
        hash_ctrl_i[1] = 1'b1;
        if (gap_pending) begin
          checkOutput("wait_rdy_stall", (cyc - end_cyc) >= (BUSY_GAP + 3), 1);
          gap_pending = 1'b0;
        end
        m_cnt++;
        if (data_ctrl_o[2]) begin
          m_cnt  = 0;
          m_wait = ANS_DELAY;
        end else if (m_cnt % BLOCK == 0) begin
          m_gap       = BUSY_GAP;
          gap_pending = 1'b1;
          end_cyc     = cyc;
        end
      end else if (m_gap > 0) begin
        m_gap--;
        if (m_gap == 0) hash_ctrl_i[1] = 1'b0;
      end
      if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) begin
          hash_ctrl_i[1] = 1'b0;
          if (!never_answer) begin
            m_left = ans_count;
            m_idx  = 0;
          end
        end
      end
      if (m_left > 0) begin
        hash_ctrl_i[0] = 1'b1;
        hash_i         = ans_base + 8'(m_idx);
        m_idx++;
        m_left--;
      end else begin
        hash_ctrl_i[0] = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "[TB] aborted");
  end

  initial begin
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_outputs", {data_o, data_ctrl_o, msg_ready_o, res_valid_o, res_data_o, res_last_o, busy_o, error_o}, 0);
    @(negedge clk);
    rst_async = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("idle_ready_busy", {msg_ready_o, busy_o}, 0);

    $display("[TB] one-byte message");
    ans_count = HASH; ans_base = 8'h00;
    applyStimulus(1, 8'h61, -1, -1);
    expectDigest(8'h00, HASH);
    waitDigest("one_byte");
    checkOutput("one_byte_err", error_o, 0);
    checkOutput("one_byte_busy", busy_o, 0);

    $display("[TB] 130-byte message");
    ans_base = 8'h80;
    applyStimulus(130, 8'h10, -1, 30);
    expectDigest(8'h80, HASH);
    waitDigest("msg130");
    checkOutput("msg130_err", error_o, 0);

    $display("[TB] 64-byte message");
    ans_base = 8'h20;
    applyStimulus(64, 8'h33, -1, -1);
    expectDigest(8'h20, HASH);
    waitDigest("msg64");
    checkOutput("msg64_err", error_o, 0);
    checkOutput("msg64_busy", busy_o, 0);

`ifdef BLAKE2_HOST_TIMEOUT_EN
    begin
      int t0;
      int guard;
      $display("[TB] watchdog timeout");
      never_answer = 1'b1;
      applyStimulus(1, 8'h77, -1, -1);
      t0 = cyc;
      guard = 0;
      while (busy_o && guard < 600) begin
        @(negedge clk);
        #1;
        guard++;
      end
      checkOutput("wdog_busy_fall", busy_o, 0);
      checkOutput("wdog_error", error_o, 1);
      checkOutput("wdog_latency", (cyc - t0) >= 250 && (cyc - t0) <= 262, 1);
      never_answer = 1'b0;
      repeat (5) @(negedge clk);
    end
`endif

    $display("[TB] digest dropped after 20 bytes");
    ans_count = 20; ans_base = 8'h50;
    applyStimulus(3, 8'hC0, -1, -1);
    expectDigest(8'h50, 20);
    waitDigest("drop");
    checkOutput("drop_err", error_o, 1);
    checkOutput("drop_busy", busy_o, 0);
    repeat (30) @(negedge clk);
    #1;
    checkOutput("drop_err_sticky", error_o, 1);
    ans_count = HASH;

    $display("[TB] reset during SEND");
    applyStimulus(40, 8'h90, 10, -1);
    @(negedge clk);
    #1;
    rst_async = 1'b1;
    #1;
    checkOutput("abort_ctrl", data_ctrl_o, 0);
    checkOutput("abort_data", data_o, 0);
    checkOutput("abort_ready_busy", {msg_ready_o, busy_o}, 0);
    checkOutput("abort_err_clear", error_o, 0);
    repeat (2) @(negedge clk);
    rst_async = 1'b0;
    repeat (2) @(negedge clk);
    ans_base = 8'h40;
    applyStimulus(5, 8'h01, -1, -1);
    expectDigest(8'h40, HASH);
    waitDigest("after_rst");
    checkOutput("after_rst_err", error_o, 0);
    checkOutput("beat_q_empty", exp_beat_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
